cac_combine_pipe: RTL
=====================

Name: cac_combine_pipe

Overview:
- Two-lane compare-and-combine stage for the scatter/gather update path.
- Orders each incoming (dest_vid, update) pair so lane A carries the smaller destination.
- After a fixed, parameterised latency, merges the pair into lane A when both lanes target the same vertex.
- Successor to the fixed 3-deep adder-only unit. Adds a selectable combine op, latency-matched combine pipeline, backpressure, per-lane destination pass-through and statistics counters.

Parameters:
DATA_W, 32, width of dest_vid and update fields
COMB_LAT, 2, register stages inside the combine sub-module (>=1); total latency = COMB_LAT+1
CNT_W, 32, width of statistics counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid_a  in  1  lane A input valid
in_valid_b  in  1  lane B input valid
in_dest_a  in  DATA_W  lane A destination vertex id
in_dest_b  in  DATA_W  lane B destination vertex id
in_upd_a  in  DATA_W  lane A update value
in_upd_b  in  DATA_W  lane B update value
in_op  in  2  combine op for this pair: 0 ADD, 1 MIN, 2 MAX, 3 KEEP_A
in_ready  out  1  input accepted this cycle when high
out_ready  in  1  downstream can accept
out_valid_a  out  1  lane A output valid
out_valid_b  out  1  lane B output valid
out_dest_a  out  DATA_W  lane A destination
out_dest_b  out  DATA_W  lane B destination
out_upd_a  out  DATA_W  lane A update (combined when merged)
out_upd_b  out  DATA_W  lane B update
cnt_clr  in  1  synchronous clear of both counters
pair_cnt  out  CNT_W  input beats accepted with at least one valid
merge_cnt  out  CNT_W  output beats where a merge occurred

Behaviour:
- Clocking and reset: one clock (clk). rst is asynchronous and active-high. It clears every pipeline register, the combine pipeline and both counters, so all out_* are 0 and both counters are 0.
- Enable: en = out_ready. in_ready = out_ready, combinationally. When en=0, every register holds, including the combine stages and the carried op. Outputs stay stable.
- Stage 0 (sort), registered when en=1:
  - swap = in_valid_a & in_valid_b & (in_dest_b < in_dest_a), unsigned compare.
  - On swap, lane A takes all of B's fields and B takes all of A's.
  - Equal destinations, or a single valid lane, never swap.
  - in_op is registered alongside.
- Delay line: valid, dest, upd and op are carried through COMB_LAT further stages. Output is the last stage, so latency = COMB_LAT+1 enabled cycles.
- combine unit:
  - Fed from stage-0 upd_a, upd_b and op.
  - Has COMB_LAT registers, advances only on en, reset by rst.
  - ADD: (a+b) mod 2^DATA_W, unsigned wrap.
  - MIN / MAX: unsigned min / max.
  - KEEP_A: returns a.
  - Its result is aligned with the last delay stage by construction.
- Merge at output: merge = vA & vB & (destA == destB) on the last stage.
  - merge=1: out_upd_a = combined result; out_valid_b = 0; out_upd_b = 0; out_dest_b = destB (unchanged).
  - merge=0: both lanes pass through unchanged, and upd_b is passed even when invalid.
  - out_dest_a and out_dest_b always come from their own lanes.
- Counters:
  - pair_cnt increments on in_ready & (in_valid_a | in_valid_b).
  - merge_cnt increments on out_ready & merge.
  - Both saturate at all-ones.
  - cnt_clr has priority over increment in the same cycle.
- Boundary conditions:
  - Invalid lanes still propagate data but never merge.
  - An async rst mid-stream drops all in-flight pairs. No output valid is asserted until new inputs traverse the full latency.
  - out_ready low for any number of cycles loses no data. An input presented while in_ready=0 is ignored.

Decomposition:
- Package cac_pkg:
  - op encodings OP_ADD=0, OP_MIN=1, OP_MAX=2, OP_KEEP_A=3;
  - function cac_combine(op, a, b) returning DATA_W bits, shared by RTL and bench model.
- Sub-module cac_combine_unit (op decode plus COMB_LAT-deep enabled register pipeline).
- Top holds the sort, delay line, merge mux and counters.

Test Plan:
- Merge, ADD: COMB_LAT=2, out_ready=1; A=(dest 5, upd 10), B=(dest 5, upd 7), ADD.
  - At cycle 3: out_valid_a=1, out_dest_a=5, out_upd_a=17, out_valid_b=0, out_upd_b=0, merge_cnt=1.
- Swap: A=(9, 1), B=(4, 2), ADD.
  - Output: A=(4, 2), B=(9, 1), both valid, no merge.
- MIN / MAX: dest equal, upd 0x30 and 0x12.
  - MIN gives out_upd_a=0x12; MAX gives 0x30.
  - ADD of 0xFFFFFFFF+2 gives 0x00000001 (wrap).
- Backpressure: 4 back-to-back merging pairs; drop out_ready for 3 cycles mid-stream.
  - All 4 results appear in order and unchanged; in_ready low during the stall; merge_cnt=4.
- Single-lane: in_valid_a=0, B=(3, 8).
  - Output valid_b=1, dest_b=3, upd_b=8, no swap, no merge; pair_cnt counts it.
- Reset and clear: assert rst asynchronously with 2 pairs in flight.
  - All outputs and counters go 0 immediately; no stale valids afterwards.
  - cnt_clr together with a merge leaves merge_cnt=0.

Source files
------------

// File: rtl/cac_pkg.sv
// rtl/cac_pkg.sv - shared op encodings and combine function for the compare-and-combine stage
package cac_pkg;

  // Widest operand the shared combine function supports; callers zero-extend and truncate.
  localparam int CAC_MAX_W = 64;

  typedef enum logic [1:0] {
    OP_ADD    = 2'd0,
    OP_MIN    = 2'd1,
    OP_MAX    = 2'd2,
    OP_KEEP_A = 2'd3
  } cac_op_e;

  // Unsigned combine on zero-extended operands; truncating the result to the
  // caller's width gives the modulo-2^W wrap for ADD.
  function automatic logic [CAC_MAX_W-1:0] cac_combine(
    input cac_op_e              op,
    input logic [CAC_MAX_W-1:0] a,
    input logic [CAC_MAX_W-1:0] b
  );
    logic [CAC_MAX_W-1:0] r;
    r = a;
    case (op)
      OP_ADD:    r = a + b;
      OP_MIN:    r = (a < b) ? a : b;
      OP_MAX:    r = (a > b) ? a : b;
      OP_KEEP_A: r = a;
      default:   r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cac_combine_unit.sv
// rtl/cac_combine_unit.sv - op decode followed by a COMB_LAT-deep enabled result pipeline
module cac_combine_unit
  import cac_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int COMB_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] pipe [COMB_LAT];
  logic [DATA_W-1:0] comb_now;

  assign comb_now = DATA_W'(cac_combine(cac_op_e'(op), CAC_MAX_W'(a), CAC_MAX_W'(b)));

  // First stage captures the combined value, later stages only delay it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < COMB_LAT; i++) begin
        pipe[i] <= '0;
      end
    end else if (en) begin
      pipe[0] <= comb_now;
      for (int i = 1; i < COMB_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign result = pipe[COMB_LAT-1];

endmodule

// File: rtl/cac_combine_pipe.sv
// rtl/cac_combine_pipe.sv - two-lane sort, latency-matched combine and merge with statistics
module cac_combine_pipe
  import cac_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int COMB_LAT = 2,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_a,
  input  logic              in_valid_b,
  input  logic [DATA_W-1:0] in_dest_a,
  input  logic [DATA_W-1:0] in_dest_b,
  input  logic [DATA_W-1:0] in_upd_a,
  input  logic [DATA_W-1:0] in_upd_b,
  input  logic [1:0]        in_op,
  output logic              in_ready,
  input  logic              out_ready,
  output logic              out_valid_a,
  output logic              out_valid_b,
  output logic [DATA_W-1:0] out_dest_a,
  output logic [DATA_W-1:0] out_dest_b,
  output logic [DATA_W-1:0] out_upd_a,
  output logic [DATA_W-1:0] out_upd_b,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  pair_cnt,
  output logic [CNT_W-1:0]  merge_cnt
);

  localparam int LAST = COMB_LAT - 1;

  logic              en;
  logic              swap;
  logic              merge;
  logic              accept_in;
  logic              merge_beat;
  logic [DATA_W-1:0] comb_res;

  logic              s0_va;
  logic              s0_vb;
  logic [DATA_W-1:0] s0_da;
  logic [DATA_W-1:0] s0_db;
  logic [DATA_W-1:0] s0_ua;
  logic [DATA_W-1:0] s0_ub;
  logic [1:0]        s0_op;

  logic              dl_va [COMB_LAT];
  logic              dl_vb [COMB_LAT];
  logic [DATA_W-1:0] dl_da [COMB_LAT];
  logic [DATA_W-1:0] dl_db [COMB_LAT];
  logic [DATA_W-1:0] dl_ua [COMB_LAT];
  logic [DATA_W-1:0] dl_ub [COMB_LAT];

  // Whole pipeline, combine stages included, advances only when downstream accepts.
  assign en       = out_ready;
  assign in_ready = out_ready;

  // Equal destinations and single-valid pairs keep their lane order.
  assign swap = in_valid_a & in_valid_b & (in_dest_b < in_dest_a);

  // Stage 0: sort so lane A carries the smaller destination.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_va <= 1'b0;
      s0_vb <= 1'b0;
      s0_da <= '0;
      s0_db <= '0;
      s0_ua <= '0;
      s0_ub <= '0;
      s0_op <= '0;
    end else if (en) begin
      s0_va <= swap ? in_valid_b : in_valid_a;
      s0_vb <= swap ? in_valid_a : in_valid_b;
      s0_da <= swap ? in_dest_b  : in_dest_a;
      s0_db <= swap ? in_dest_a  : in_dest_b;
      s0_ua <= swap ? in_upd_b   : in_upd_a;
      s0_ub <= swap ? in_upd_a   : in_upd_b;
      s0_op <= in_op;
    end
  end

  // Delay line matching the combine unit depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < COMB_LAT; i++) begin
        dl_va[i] <= 1'b0;
        dl_vb[i] <= 1'b0;
        dl_da[i] <= '0;
        dl_db[i] <= '0;
        dl_ua[i] <= '0;
        dl_ub[i] <= '0;
      end
    end else if (en) begin
      dl_va[0] <= s0_va;
      dl_vb[0] <= s0_vb;
      dl_da[0] <= s0_da;
      dl_db[0] <= s0_db;
      dl_ua[0] <= s0_ua;
      dl_ub[0] <= s0_ub;
      for (int i = 1; i < COMB_LAT; i++) begin
        dl_va[i] <= dl_va[i-1];
        dl_vb[i] <= dl_vb[i-1];
        dl_da[i] <= dl_da[i-1];
        dl_db[i] <= dl_db[i-1];
        dl_ua[i] <= dl_ua[i-1];
        dl_ub[i] <= dl_ub[i-1];
      end
    end
  end

  cac_combine_unit #(
    .DATA_W   (DATA_W),
    .COMB_LAT (COMB_LAT)
  ) u_combine (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .op     (s0_op),
    .a      (s0_ua),
    .b      (s0_ub),
    .result (comb_res)
  );

  // Merge mux on the last stage; destinations always come from their own lane.
  assign merge       = dl_va[LAST] & dl_vb[LAST] & (dl_da[LAST] == dl_db[LAST]);
  assign out_valid_a = dl_va[LAST];
  assign out_valid_b = dl_vb[LAST] & ~merge;
  assign out_dest_a  = dl_da[LAST];
  assign out_dest_b  = dl_db[LAST];
  assign out_upd_a   = merge ? comb_res : dl_ua[LAST];
  assign out_upd_b   = merge ? '0 : dl_ub[LAST];

  assign accept_in  = in_ready & (in_valid_a | in_valid_b);
  assign merge_beat = out_ready & merge;

  // Saturating statistics; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_cnt  <= '0;
      merge_cnt <= '0;
    end else if (cnt_clr) begin
      pair_cnt  <= '0;
      merge_cnt <= '0;
    end else begin
      if (accept_in && (pair_cnt != '1)) begin
        pair_cnt <= pair_cnt + CNT_W'(1);
      end
      if (merge_beat && (merge_cnt != '1)) begin
        merge_cnt <= merge_cnt + CNT_W'(1);
      end
    end
  end

endmodule
